usb_rx_phy: RTL and testbench
=============================

Name: usb_rx_phy

Overview:
- Front-end receive stage that sits directly upstream of the USB packet reader.
- Synchronises raw D+/D- pins to clock48 and recovers bit timing from 4x oversampling (12 Mb/s full speed).
- Detects SYNC, NRZI-decodes, strips stuffed bits and detects EOP and bus reset.
- Emits a clean per-bit strobe stream framed by rx_active, so the downstream reader no longer handles line-level decoding.

Parameters:
- RESET_CYCLES, 120: consecutive SE0 clocks (2.5 us at 48 MHz) before bus_reset asserts.
- SYNC_TIMEOUT, 16: maximum bit samples in SYNC without seeing the KK terminator before aborting.

Ports:
- clock48  in  1  48 MHz system clock.
- reset_n  in  1  asynchronous active-low reset.
- usb_d_p  in  1  raw D+ pin, asynchronous.
- usb_d_n  in  1  raw D- pin, asynchronous.
- rx_active  out  1  high from the last SYNC bit until packet_end or abort.
- bit_valid  out  1  one-clock strobe: bit_data holds a decoded, unstuffed payload bit.
- bit_data  out  1  decoded bit, LSB-first wire order.
- packet_end  out  1  one-clock pulse on a valid EOP (SE0, SE0, J).
- rx_error  out  1  one-clock pulse on stuff error, SYNC timeout or malformed EOP.
- bus_reset  out  1  level, high while SE0 has persisted for at least RESET_CYCLES.

Behaviour:
- Reset: reset_n low asynchronously clears all outputs to 0, FSM to IDLE, prev_line to J, phase and all counters to 0.
- Synchroniser: 2-flop on each of usb_d_p and usb_d_n. Line state is decoded from the synchronised pair: J = 10, K = 01, SE0 = 00, SE1 = 11. SE1 is treated as SE0.
- Latency: pin to line state is 2 clocks.
- Bit clock recovery: 2-bit phase counter.
  - Reset to 0 on any change of the synchronised line state.
  - Otherwise increments, wrapping 3 -> 0.
  - A sample is taken when phase == 2 (mid-bit).
  - Back-to-back transitions faster than 4 clocks simply re-centre; no error.
- NRZI: decoded bit = 1 if the sampled line equals prev_line, else 0. prev_line updates on every sample.
- Stuffing: ones counter (3 bits) increments on a decoded 1 and clears on a decoded 0.
  - When the counter reaches 6, the next sample is a stuff bit.
  - If that stuff bit decodes 0, it is dropped (no bit_valid) and the counter clears.
  - If it decodes 1, rx_error pulses and the FSM goes to ABORT.
- FSM states:
  - IDLE: line J. A sampled K -> SYNC, sync counter = 1, prev_line = K.
  - SYNC: on each sample the sync counter increments.
    - Two consecutive K samples -> ACTIVE: rx_active rises the same cycle, ones counter = 0. SYNC bits are never strobed.
    - SE0 sample -> IDLE with no error.
    - Counter > SYNC_TIMEOUT -> rx_error, ABORT.
  - ACTIVE: J/K samples emit bit_valid/bit_data on the sample cycle (registered, so visible 1 clock after phase == 2). An SE0 sample -> EOP1.
  - EOP1: the next sample must be SE0 -> EOP2; otherwise rx_error, ABORT.
  - EOP2: the next sample must be J -> packet_end pulse, rx_active falls the same cycle, IDLE. Otherwise rx_error, ABORT.
  - ABORT: rx_active low. Waits until the line has been J for 8 consecutive clocks, then IDLE.
- Bus reset:
  - An SE0 counter (saturating, wide enough for RESET_CYCLES) increments on every SE0 clock and clears on non-SE0.
  - bus_reset is high while counter >= RESET_CYCLES.
  - A rising bus_reset forces the FSM to IDLE and rx_active low; no packet_end or rx_error is generated for it.
- Simultaneous events:
  - A bus_reset rise overrides any FSM transition in the same cycle.
  - rx_error and packet_end are never both high.
  - A bit_valid strobe can never coincide with packet_end.
- Mid-packet reset: assertion of reset_n drops all outputs immediately; a packet in flight is lost and no packet_end is issued.

Decomposition:
- Package usb_pkg holds:
  - line-state encodings LINE_J, LINE_K, LINE_SE0;
  - FSM state constants RX_IDLE, RX_SYNC, RX_ACTIVE, RX_EOP1, RX_EOP2, RX_ABORT;
  - the full-speed oversample ratio constant (4).
- One sub-module, usb_line_sync:
  - contains the 2-flop synchroniser, line-state decode and phase counter;
  - outputs line_state and sample_strobe;
  - is reusable by a future low-speed receiver.
- The FSM, NRZI, stuffing and bus-reset logic stay in usb_rx_phy.

Test Plan:
1. Drive KJKJKJKK, then NRZI data for byte 0x69 and EOP (SE0, SE0, J), 4 clocks per bit -> exactly 8 bit_valid strobes carrying 1,0,0,1,0,1,1,0; one packet_end; rx_active high for the whole payload; no rx_error.
2. Payload 0xFF 0x01 with a stuffed bit inserted after six 1s -> 16 strobes in total, the stuffed bit absent, ones counter cleared afterwards, no error.
3. Same as scenario 2 but the stuffed bit is sent as no transition -> rx_error pulse; rx_active falls; FSM returns to IDLE only after 8 clocks of J.
4. Bit periods alternating 3 and 5 clocks (jitter) over a 32-bit payload -> all 32 bits decoded correctly.
5. Hold SE0 for 119 clocks, then J -> bus_reset never asserts, and an EOP1-style error pulse only if the FSM was in ACTIVE. Hold SE0 for 120 clocks -> bus_reset high from clock 120 until SE0 ends.
6. Assert reset_n low mid-payload, release, then send a fresh packet -> all outputs 0 during reset; the fresh packet decodes cleanly with no stale bits.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared encodings for the full-speed USB receive front end.
// Line-state values match the {D+, D-} pin pair so decode is a direct mapping.
package usb_pkg;

    typedef enum logic [1:0] {
        LINE_SE0 = 2'b00,
        LINE_K   = 2'b01,
        LINE_J   = 2'b10
    } line_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_SYNC,
        RX_ACTIVE,
        RX_EOP1,
        RX_EOP2,
        RX_ABORT
    } rx_state_e;

    localparam int unsigned FS_OVERSAMPLE  = 4;
    localparam int unsigned STUFF_LIMIT    = 6;
    localparam int unsigned ABORT_J_CLOCKS = 8;

    // SE1 is illegal on the bus and is folded into SE0.
    function automatic line_e decode_line(input logic dp, input logic dn);
        unique case ({dp, dn})
            2'b10:   return LINE_J;
            2'b01:   return LINE_K;
            default: return LINE_SE0;
        endcase
    endfunction

endpackage

// File: rtl/usb_rx_phy_if.sv
// Pin inputs and decoded bit-stream outputs of the USB receive front end.
// master is the PHY side, slave is the downstream packet reader / pin driver.
interface usb_rx_phy_if;
    logic usb_d_p;
    logic usb_d_n;
    logic rx_active;
    logic bit_valid;
    logic bit_data;
    logic packet_end;
    logic rx_error;
    logic bus_reset;

    modport master (
        input  usb_d_p, usb_d_n,
        output rx_active, bit_valid, bit_data, packet_end, rx_error, bus_reset
    );

    modport slave (
        output usb_d_p, usb_d_n,
        input  rx_active, bit_valid, bit_data, packet_end, rx_error, bus_reset
    );
endinterface

// File: rtl/usb_line_sync.sv
// Pin synchroniser, line-state decode and oversampled bit-centre recovery.
// OVERSAMPLE must be a power of two so the phase counter wraps naturally.
module usb_line_sync
    import usb_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = FS_OVERSAMPLE
) (
    input  logic  clock48,
    input  logic  reset_n,
    input  logic  usb_d_p,
    input  logic  usb_d_n,
    output line_e line_state,
    output logic  sample_strobe
);

    localparam int unsigned PW = $clog2(OVERSAMPLE);
    localparam logic [PW-1:0] MID = PW'(OVERSAMPLE / 2);

    logic [1:0]    dp_sync;
    logic [1:0]    dn_sync;
    line_e         line_prev;
    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase;

    // Synchronisers idle at J so a reset release does not look like SE0.
    always_ff @(posedge clock48 or negedge reset_n) begin
        if (!reset_n) begin
            dp_sync   <= 2'b11;
            dn_sync   <= 2'b00;
            line_prev <= LINE_J;
            phase_q   <= '0;
        end else begin
            dp_sync   <= {dp_sync[0], usb_d_p};
            dn_sync   <= {dn_sync[0], usb_d_n};
            line_prev <= line_state;
            phase_q   <= phase;
        end
    end

    assign line_state = decode_line(dp_sync[1], dn_sync[1]);

    // The clock on which the line changes counts as phase 0 of the new bit.
    assign phase         = (line_state != line_prev) ? '0 : phase_q + PW'(1);
    assign sample_strobe = (phase == MID);

endmodule

// File: rtl/usb_rx_phy.sv
// Full-speed USB receive PHY: SYNC detect, NRZI decode, bit unstuffing,
// EOP and bus-reset detection, producing a framed per-bit strobe stream.
module usb_rx_phy
    import usb_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 120,
    parameter int unsigned SYNC_TIMEOUT = 16
) (
    input logic          clock48,
    input logic          reset_n,
    usb_rx_phy_if.master bus
);

    localparam int unsigned SE0_W  = $clog2(RESET_CYCLES + 1);
    localparam int unsigned SYNC_W = $clog2(SYNC_TIMEOUT + 2);

    line_e line_state;
    logic  sample_strobe;

    usb_line_sync #(
        .OVERSAMPLE (FS_OVERSAMPLE)
    ) u_line_sync (
        .clock48       (clock48),
        .reset_n       (reset_n),
        .usb_d_p       (bus.usb_d_p),
        .usb_d_n       (bus.usb_d_n),
        .line_state    (line_state),
        .sample_strobe (sample_strobe)
    );

    rx_state_e         state;
    line_e             prev_line;
    logic [2:0]        ones_cnt;
    logic [SYNC_W-1:0] sync_cnt;
    logic [SE0_W-1:0]  se0_cnt;
    logic [3:0]        j_cnt;
    logic              rx_active;
    logic              bit_valid;
    logic              bit_data;
    logic              packet_end;
    logic              rx_error;
    logic              bus_reset;

    logic              is_se0;
    logic              nrzi_bit;
    logic              reset_rise;
    logic [SE0_W-1:0]  se0_next;
    logic [SYNC_W-1:0] sync_next;

    always_comb begin
        is_se0     = (line_state == LINE_SE0);
        nrzi_bit   = (line_state == prev_line);
        sync_next  = sync_cnt + SYNC_W'(1);
        se0_next   = '0;
        if (is_se0) begin
            se0_next = (se0_cnt == SE0_W'(RESET_CYCLES)) ? se0_cnt : se0_cnt + SE0_W'(1);
        end
        reset_rise = (se0_next >= SE0_W'(RESET_CYCLES)) && !bus_reset;
    end

    always_ff @(posedge clock48 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RX_IDLE;
            prev_line  <= LINE_J;
            ones_cnt   <= '0;
            sync_cnt   <= '0;
            se0_cnt    <= '0;
            j_cnt      <= '0;
            rx_active  <= 1'b0;
            bit_valid  <= 1'b0;
            bit_data   <= 1'b0;
            packet_end <= 1'b0;
            rx_error   <= 1'b0;
            bus_reset  <= 1'b0;
        end else begin
            bit_valid  <= 1'b0;
            packet_end <= 1'b0;
            rx_error   <= 1'b0;
            se0_cnt    <= se0_next;
            bus_reset  <= (se0_next >= SE0_W'(RESET_CYCLES));
            if (sample_strobe) begin
                prev_line <= line_state;
            end

            // A fresh bus reset silently discards whatever the FSM was doing.
            if (reset_rise) begin
                state     <= RX_IDLE;
                rx_active <= 1'b0;
            end else begin
                unique case (state)
                    RX_IDLE: begin
                        if (sample_strobe && line_state == LINE_K) begin
                            state    <= RX_SYNC;
                            sync_cnt <= SYNC_W'(1);
                        end
                    end
                    RX_SYNC: begin
                        if (sample_strobe) begin
                            sync_cnt <= sync_next;
                            if (line_state == LINE_K && prev_line == LINE_K) begin
                                state     <= RX_ACTIVE;
                                rx_active <= 1'b1;
                                ones_cnt  <= '0;
                            end else if (is_se0) begin
                                state <= RX_IDLE;
                            end else if (sync_next > SYNC_W'(SYNC_TIMEOUT)) begin
                                state    <= RX_ABORT;
                                rx_error <= 1'b1;
                                j_cnt    <= '0;
                            end
                        end
                    end
                    RX_ACTIVE: begin
                        if (sample_strobe) begin
                            if (is_se0) begin
                                state <= RX_EOP1;
                            end else if (ones_cnt == 3'(STUFF_LIMIT)) begin
                                // This slot must be a stuffed 0; a 1 here is a stuff error.
                                if (nrzi_bit) begin
                                    state     <= RX_ABORT;
                                    rx_error  <= 1'b1;
                                    rx_active <= 1'b0;
                                    j_cnt     <= '0;
                                end else begin
                                    ones_cnt <= '0;
                                end
                            end else begin
                                bit_valid <= 1'b1;
                                bit_data  <= nrzi_bit;
                                ones_cnt  <= nrzi_bit ? ones_cnt + 3'd1 : 3'd0;
                            end
                        end
                    end
                    RX_EOP1: begin
                        if (sample_strobe) begin
                            if (is_se0) begin
                                state <= RX_EOP2;
                            end else begin
                                state     <= RX_ABORT;
                                rx_error  <= 1'b1;
                                rx_active <= 1'b0;
                                j_cnt     <= '0;
                            end
                        end
                    end
                    RX_EOP2: begin
                        if (sample_strobe) begin
                            if (line_state == LINE_J) begin
                                state      <= RX_IDLE;
                                packet_end <= 1'b1;
                                rx_active  <= 1'b0;
                            end else begin
                                state     <= RX_ABORT;
                                rx_error  <= 1'b1;
                                rx_active <= 1'b0;
                                j_cnt     <= '0;
                            end
                        end
                    end
                    RX_ABORT: begin
                        rx_active <= 1'b0;
                        if (line_state == LINE_J) begin
                            if (j_cnt == 4'(ABORT_J_CLOCKS - 1)) begin
                                state <= RX_IDLE;
                                j_cnt <= '0;
                            end else begin
                                j_cnt <= j_cnt + 4'd1;
                            end
                        end else begin
                            j_cnt <= '0;
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

    assign bus.rx_active  = rx_active;
    assign bus.bit_valid  = bit_valid;
    assign bus.bit_data   = bit_data;
    assign bus.packet_end = packet_end;
    assign bus.rx_error   = rx_error;
    assign bus.bus_reset  = bus_reset;

endmodule

// File: tb/tb_usb_rx_phy.sv
// Directed and randomised packets for usb_rx_phy, checked against payloads the
// bench itself encodes (stuffing, NRZI, SYNC/EOP framing) at the wire level.
module tb_usb_rx_phy;

    localparam logic [1:0] PJ   = 2'b10;
    localparam logic [1:0] PK   = 2'b01;
    localparam logic [1:0] PSE0 = 2'b00;

    logic clock48 = 1'b0;
    logic reset_n = 1'b1;

    usb_rx_phy_if bus ();

    usb_rx_phy #(
        .RESET_CYCLES (120),
        .SYNC_TIMEOUT (16)
    ) dut (
        .clock48 (clock48),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock48 = ~clock48;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] wave[$];
    bit         exp_bits[$];
    bit         got_bits[$];
    int         pe_cnt = 0;
    int         err_cnt = 0;
    int         br_cnt = 0;

    // Monitor: collects strobed bits and pulse counts away from the active edge.
    always @(negedge clock48) begin
        if (bus.bit_valid === 1'b1) begin
            got_bits.push_back(bus.bit_data);
            checks++;
            assert (bus.rx_active === 1'b1) else begin
                errors++;
                $error("FAIL active_at_strobe: observed %b expected 1", bus.rx_active);
            end
        end
        if (bus.packet_end === 1'b1) pe_cnt++;
        if (bus.rx_error === 1'b1) err_cnt++;
        if (bus.bus_reset === 1'b1) br_cnt++;
        if (bus.packet_end === 1'b1 || bus.rx_error === 1'b1) begin
            checks++;
            assert ((bus.packet_end & (bus.rx_error | bus.bit_valid)) === 1'b0) else begin
                errors++;
                $error("FAIL pulse_exclusive: observed pe=%b err=%b bv=%b expected pe alone",
                       bus.packet_end, bus.rx_error, bus.bit_valid);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_level(input logic [1:0] lv, input int n);
        for (int i = 0; i < n; i++) wave.push_back(lv);
    endtask

    // Encodes SYNC + payload (LSB first, stuff 0 after six 1s) + EOP as pin levels.
    // corrupt sends the first stuff bit as a 1; expect adds payload bits to exp_bits.
    task automatic build_packet(input logic [63:0] payload, input int nbits, input bit jitter,
                                input bit corrupt, input bit expect_bits, input int se0_clocks);
        logic [1:0] lv = PJ;
        int ones = 0;
        bit stopped = 1'b0;
        bit wire_bits[$];
        for (int i = 0; i < 7; i++) wire_bits.push_back(1'b0);
        wire_bits.push_back(1'b1);
        for (int i = 0; i < nbits && !stopped; i++) begin
            wire_bits.push_back(payload[i]);
            if (expect_bits) exp_bits.push_back(payload[i]);
            ones = payload[i] ? ones + 1 : 0;
            if (ones == 6) begin
                wire_bits.push_back(corrupt);
                ones = 0;
                if (corrupt) stopped = 1'b1;
            end
        end
        foreach (wire_bits[i]) begin
            if (!wire_bits[i]) lv = (lv == PJ) ? PK : PJ;
            push_level(lv, jitter ? ((i % 2) ? 5 : 3) : 4);
        end
        push_level(PSE0, se0_clocks);
        push_level(PJ, 4);
    endtask

    task automatic drive_wave(input int upto);
        for (int i = 0; i < wave.size() && i < upto; i++) begin
            @(posedge clock48);
            #1;
            {bus.usb_d_p, bus.usb_d_n} = wave[i];
        end
        wave.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock48);
            #1;
            {bus.usb_d_p, bus.usb_d_n} = PJ;
        end
    endtask

    task automatic start_capture();
        got_bits.delete();
        exp_bits.delete();
        pe_cnt  = 0;
        err_cnt = 0;
        br_cnt  = 0;
    endtask

    task automatic check_packet(input string tag, input int exp_pe, input int exp_err);
        logic [63:0] g = '0;
        logic [63:0] e = '0;
        foreach (got_bits[i]) if (i < 64) g[i] = got_bits[i];
        foreach (exp_bits[i]) if (i < 64) e[i] = exp_bits[i];
        check({tag, "_count"}, 64'(got_bits.size()), 64'(exp_bits.size()));
        check({tag, "_bits"}, g, e);
        check({tag, "_packet_end"}, 64'(pe_cnt), 64'(exp_pe));
        check({tag, "_rx_error"}, 64'(err_cnt), 64'(exp_err));
        check({tag, "_rx_active_after"}, {63'd0, bus.rx_active}, 64'd0);
    endtask

    task automatic se0_hold(input string tag, input int n);
        start_capture();
        push_level(PSE0, n);
        push_level(PJ, 8);
        drive_wave(1 << 20);
        idle(10);
        // Registered level: high from the 120th SE0 clock until the line leaves SE0.
        check({tag, "_bus_reset_cycles"}, 64'(br_cnt), 64'((n >= 120) ? n - 119 : 0));
        check({tag, "_rx_error"}, 64'(err_cnt), 64'd0);
        check({tag, "_packet_end"}, 64'(pe_cnt), 64'd0);
    endtask

    initial begin
        logic [63:0] pl;
        int          nbytes;
        {bus.usb_d_p, bus.usb_d_n} = PJ;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clock48);
        @(negedge clock48);
        check("reset_outputs", {58'd0, bus.rx_active, bus.bit_valid, bus.bit_data,
                                bus.packet_end, bus.rx_error, bus.bus_reset}, 64'd0);
        @(posedge clock48);
        #1 reset_n = 1'b1;
        idle(10);

        // Single byte 0x69.
        start_capture();
        build_packet(64'h69, 8, 1'b0, 1'b0, 1'b1, 8);
        drive_wave(1 << 20);
        idle(12);
        check_packet("byte_69", 1, 0);

        // 0xFF 0x01 with a stuffed bit after six 1s.
        start_capture();
        build_packet(64'h01FF, 16, 1'b0, 1'b0, 1'b1, 8);
        drive_wave(1 << 20);
        idle(12);
        check_packet("stuffed", 1, 0);

        // Stuff violation, then a packet that arrives before 8 clocks of J (still aborted).
        start_capture();
        build_packet(64'h01FF, 16, 1'b0, 1'b1, 1'b1, 8);
        build_packet(64'h00, 8, 1'b0, 1'b0, 1'b0, 8);
        drive_wave(1 << 20);
        idle(20);
        check_packet("stuff_error", 0, 1);

        start_capture();
        build_packet(64'hA5, 8, 1'b0, 1'b0, 1'b1, 8);
        drive_wave(1 << 20);
        idle(12);
        check_packet("after_abort", 1, 0);

        // 32-bit payload with 3/5-clock bit periods.
        start_capture();
        pl = {32'd0, $urandom()};
        build_packet(pl, 32, 1'b1, 1'b0, 1'b1, 8);
        drive_wave(1 << 20);
        idle(12);
        check_packet("jitter32", 1, 0);

        // Random payloads, biased toward 0xFF bytes so stuffing is exercised.
        for (int n = 0; n < 6; n++) begin
            start_capture();
            nbytes = $urandom_range(1, 4);
            pl = '0;
            for (int b = 0; b < nbytes; b++) begin
                pl[b*8 +: 8] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom());
            end
            build_packet(pl, nbytes * 8, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 8);
            drive_wave(1 << 20);
            idle(12);
            check_packet($sformatf("random%0d", n), 1, 0);
        end

        // Bus reset thresholds while idle.
        se0_hold("se0_119", 119);
        idle(10);
        se0_hold("se0_120", 120);
        idle(10);
        se0_hold("se0_150", 150);
        idle(10);

        // Over-long SE0 inside a packet is a malformed EOP.
        start_capture();
        build_packet(64'h35, 8, 1'b0, 1'b0, 1'b1, 119);
        drive_wave(1 << 20);
        idle(20);
        check_packet("long_eop", 0, 1);
        check("long_eop_bus_reset", 64'(br_cnt), 64'd0);

        // Reset in the middle of a payload.
        start_capture();
        build_packet(64'hC3A5, 16, 1'b0, 1'b0, 1'b1, 8);
        drive_wave(60);
        reset_n = 1'b0;
        {bus.usb_d_p, bus.usb_d_n} = PJ;
        @(negedge clock48);
        check("midreset_outputs", {58'd0, bus.rx_active, bus.bit_valid, bus.bit_data,
                                   bus.packet_end, bus.rx_error, bus.bus_reset}, 64'd0);
        repeat (3) @(posedge clock48);
        #1 reset_n = 1'b1;
        idle(20);
        check("midreset_no_packet_end", 64'(pe_cnt), 64'd0);

        start_capture();
        build_packet(64'h5A, 8, 1'b0, 1'b0, 1'b1, 8);
        drive_wave(1 << 20);
        idle(12);
        check_packet("post_reset", 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
